uart_rx: RTL

Serial UART receiver, the receive counterpart of the accelerator's existing UART transmitter. It deserialises 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) from the asynchronous `rx` line into bytes. Received bytes feed the host command/weight-load path, one clock-wide `data_valid` strobe per good frame. Baud timing derives from the same `CLK_FREQ`/`BAUD_RATE` parameters as the transmitter, so both ends share one clock domain and line rate.

---
 rtl/uart_rx.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling FSM, one-cycle
// data_valid / frame_err strobes, BREAK state to ride out a held-low line.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync       <= 2'b11;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          // Re-check the line half a bit in; a high here was only a glitch.
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line recovers so a stuck-low rx is not a new start.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
